// File: rtl/bcd_ctrl_pkg.sv
// Shared state encoding and BCD digit limits for the BCD timer controller.
package bcd_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_PAUSE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-tick prescaler: one registered tick every TICK_DIV cycles while running.
module tick_prescaler #(
  parameter int TICK_DIV = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // hold marks the resume edge: the held value is reused rather than advanced
  always_comb begin
    cnt_nx = cnt;
    if (clr) begin
      cnt_nx = '0;
    end else if (run && !hold) begin
      cnt_nx = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      tick <= run && (cnt_nx == LAST);
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Sequencer for a bank of cascaded BCD digits: preset load, prescaled counting,
// lookahead digit enables and terminal-count stop.
//
// state | meaning
// IDLE  | loaded or reset, waiting for START
// LOAD  | one-cycle parallel load of the clamped preset
// RUN   | counting on each prescaler tick
// PAUSE | counting suspended, prescaler value held
// DONE  | terminal count reached, waiting for LOAD_REQ
module bcd_timer_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_REQ,
  input  logic              START,
  input  logic              STOP,
  input  logic              UP_MODE,
  input  logic [4*NDIG-1:0] PRESET,
  input  logic [4*NDIG-1:0] DIG_Q,
  output logic [NDIG-1:0]   DIG_ENABLE,
  output logic              DIG_LOAD,
  output logic              DIG_UP,
  output logic [4*NDIG-1:0] DIG_D,
  output logic              TICK,
  output logic              BUSY,
  output logic              DONE
);

  state_t state;
  state_t state_nx;

  logic [4*NDIG-1:0] preset_clamped;
  logic [NDIG-1:0]   at_roll;
  logic [NDIG-1:0]   lookahead;
  logic [3:0]        roll_val;
  logic              terminal;
  logic              start_run;
  logic              psc_clr;
  logic              psc_run;
  logic              psc_hold;

  assign roll_val = DIG_UP ? BCD_MAX : BCD_MIN;

  // A digit advances only when every lower digit is about to roll over,
  // so all changing digits move on the same edge.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign preset_clamped[4*i +: 4] = bcd_clamp(PRESET[4*i +: 4]);
    assign at_roll[i] = (DIG_Q[4*i +: 4] == roll_val);
    if (i == 0) begin : g_lsd
      assign lookahead[i] = 1'b1;
    end else begin : g_upper
      assign lookahead[i] = &at_roll[i-1:0];
    end
  end

  // Terminal value (all 9 up, all 0 down) is exactly "every digit at rollover".
  assign terminal = &at_roll;

  always_comb begin
    state_nx = state;
    if (LOAD_REQ) begin
      state_nx = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:  if (START && !STOP) state_nx = ST_RUN;
        ST_LOAD:  state_nx = ST_IDLE;
        ST_RUN: begin
          if (terminal)  state_nx = ST_DONE;
          else if (STOP) state_nx = ST_PAUSE;
        end
        ST_PAUSE: if (START && !STOP) state_nx = ST_RUN;
        ST_DONE:  state_nx = ST_DONE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  assign start_run = (state == ST_IDLE) && (state_nx == ST_RUN);
  assign psc_clr   = (state_nx == ST_LOAD) || start_run;
  assign psc_run   = (state_nx == ST_RUN);
  assign psc_hold  = (state == ST_PAUSE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (psc_clr),
    .run  (psc_run),
    .hold (psc_hold),
    .tick (TICK)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      DIG_UP <= 1'b1;
      DIG_D  <= '0;
      DONE   <= 1'b0;
    end else begin
      state <= state_nx;
      DONE  <= (state_nx == ST_DONE);
      if (LOAD_REQ) DIG_D <= preset_clamped;
      if (start_run) DIG_UP <= UP_MODE;
    end
  end

  always_comb begin
    DIG_ENABLE = '0;
    if (state == ST_LOAD) begin
      DIG_ENABLE = '1;
    end else if ((state == ST_RUN) && TICK && !terminal) begin
      DIG_ENABLE = lookahead;
    end
  end

  assign DIG_LOAD = (state == ST_LOAD);
  assign BUSY     = (state == ST_RUN) || (state == ST_PAUSE);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl with a behavioural digit bank and
// an integer-valued reference model of the timer.
module tb_bcd_timer_ctrl;

  localparam int NDIG     = 4;
  localparam int TICK_DIV = 3;
  localparam int MAXV     = 9999;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD_REQ = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        UP_MODE = 1'b0;
  logic [15:0] PRESET = '0;
  logic [15:0] bank = '0;
  logic [3:0]  DIG_ENABLE;
  logic        DIG_LOAD;
  logic        DIG_UP;
  logic [15:0] DIG_D;
  logic        TICK;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  bcd_timer_ctrl #(.NDIG(NDIG), .TICK_DIV(TICK_DIV)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD_REQ   (LOAD_REQ),
    .START      (START),
    .STOP       (STOP),
    .UP_MODE    (UP_MODE),
    .PRESET     (PRESET),
    .DIG_Q      (bank),
    .DIG_ENABLE (DIG_ENABLE),
    .DIG_LOAD   (DIG_LOAD),
    .DIG_UP     (DIG_UP),
    .DIG_D      (DIG_D),
    .TICK       (TICK),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic up);
    if (up) return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Behavioural digit bank driven by the controller outputs.
  always @(posedge CLK) begin
    if (DIG_LOAD) begin
      bank <= DIG_D;
    end else begin
      for (int i = 0; i < NDIG; i++)
        if (DIG_ENABLE[i]) bank[4*i +: 4] <= next_digit(bank[4*i +: 4], DIG_UP);
    end
  end

  function automatic logic [15:0] clamp(input logic [15:0] p);
    logic [15:0] r;
    r = p;
    for (int i = 0; i < NDIG; i++)
      if (p[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int div;
    div = 1;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  // Digits whose decimal value differs between a and b.
  function automatic logic [3:0] diff_mask(input int a, input int b);
    logic [3:0] m;
    int div;
    div = 1;
    m = '0;
    for (int i = 0; i < NDIG; i++) begin
      m[i] = ((a / div) % 10) != ((b / div) % 10);
      div = div * 10;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [15:0] p);
    PRESET = p;
    LOAD_REQ = 1'b1;
    cyc();
    LOAD_REQ = 1'b0;
    chk("load_strobe", 32'(DIG_LOAD), 32'd1);
    chk("load_data", 32'(DIG_D), 32'(clamp(p)));
    chk("load_enable", 32'(DIG_ENABLE), 32'hF);
    cyc();
    chk("load_bank", 32'(bank), 32'(clamp(p)));
    chk("load_idle_busy", 32'(BUSY), 32'd0);
    chk("load_idle_strobe", 32'(DIG_LOAD), 32'd0);
  endtask

  task automatic start_run(input logic up);
    UP_MODE = up;
    START = 1'b1;
    cyc();
    START = 1'b0;
    chk("start_dir", 32'(DIG_UP), 32'(up));
  endtask

  // Reference: tick every TICK_DIV RUN cycles; each tick moves the integer
  // count by one; the cycle showing the terminal value is the last RUN cycle.
  task automatic run_check(input logic up, input int start_val, input int ncyc);
    int  val;
    int  phase;
    bit  done_m;
    bit  term;
    bit  etick;
    int  nxt;
    val = start_val;
    phase = 0;
    done_m = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      chk("run_bank", 32'(bank), 32'(int2bcd(val)));
      if (done_m) begin
        chk("done_flag", 32'(DONE), 32'd1);
        chk("done_busy", 32'(BUSY), 32'd0);
        chk("done_tick", 32'(TICK), 32'd0);
        chk("done_enable", 32'(DIG_ENABLE), 32'd0);
      end else begin
        term  = up ? (val == MAXV) : (val == 0);
        etick = (phase == TICK_DIV - 1);
        nxt   = up ? val + 1 : val - 1;
        chk("run_busy", 32'(BUSY), 32'd1);
        chk("run_done", 32'(DONE), 32'd0);
        chk("run_tick", 32'(TICK), 32'(etick));
        chk("run_enable", 32'(DIG_ENABLE),
            32'((etick && !term) ? diff_mask(val, nxt) : 4'd0));
        if (term) begin
          done_m = 1'b1;
        end else begin
          if (etick) val = nxt;
          phase = (phase + 1) % TICK_DIV;
        end
      end
      cyc();
    end
  endtask

  initial begin
    logic [15:0] saved;
    logic [15:0] raw;
    logic        up;
    int          sval;

    cyc();
    cyc();
    RST = 1'b0;
    chk("rst_enable", 32'(DIG_ENABLE), 32'd0);
    chk("rst_load", 32'(DIG_LOAD), 32'd0);
    chk("rst_up", 32'(DIG_UP), 32'd1);
    chk("rst_d", 32'(DIG_D), 32'd0);
    chk("rst_tick", 32'(TICK), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);

    do_load(16'h1A05);
    chk("clamp_bank", 32'(bank), 32'h1905);
    cyc();
    chk("clamp_stays_idle", 32'(BUSY), 32'd0);

    do_load(16'h0009);
    start_run(1'b1);
    run_check(1'b1, 9, 8);
    chk("carry_bank", 32'(bank), 32'h0011);

    do_load(16'h0003);
    start_run(1'b0);
    run_check(1'b0, 3, 14);
    START = 1'b1;
    cyc();
    START = 1'b0;
    chk("done_ignores_start", 32'(DONE), 32'd1);
    chk("done_no_busy", 32'(BUSY), 32'd0);
    cyc();
    chk("done_bank_zero", 32'(bank), 32'h0000);

    do_load(16'h0999);
    start_run(1'b1);
    run_check(1'b1, 999, 4);
    chk("ripple_bank", 32'(bank), 32'h1000);

    do_load(16'h0100);
    start_run(1'b1);
    cyc();
    chk("pre_pause_tick", 32'(TICK), 32'd0);
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pause_tick", 32'(TICK), 32'd0);
      chk("pause_busy", 32'(BUSY), 32'd1);
      chk("pause_enable", 32'(DIG_ENABLE), 32'd0);
      cyc();
    end
    START = 1'b1;
    cyc();
    START = 1'b0;
    chk("resume_tick0", 32'(TICK), 32'd0);
    cyc();
    chk("resume_tick1", 32'(TICK), 32'd1);
    chk("resume_enable", 32'(DIG_ENABLE), 32'h1);
    cyc();
    chk("resume_bank", 32'(bank), 32'h0101);

    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_enable", 32'(DIG_ENABLE), 32'd0);
    chk("midrst_load", 32'(DIG_LOAD), 32'd0);
    chk("midrst_up", 32'(DIG_UP), 32'd1);
    chk("midrst_d", 32'(DIG_D), 32'd0);
    chk("midrst_tick", 32'(TICK), 32'd0);
    saved = bank;
    cyc();
    chk("midrst_bank_kept", 32'(bank), 32'(saved));

    PRESET = 16'h0042;
    UP_MODE = 1'b0;
    LOAD_REQ = 1'b1;
    START = 1'b1;
    cyc();
    LOAD_REQ = 1'b0;
    START = 1'b0;
    chk("ldst_strobe", 32'(DIG_LOAD), 32'd1);
    chk("ldst_busy", 32'(BUSY), 32'd0);
    cyc();
    chk("ldst_bank", 32'(bank), 32'h0042);
    chk("ldst_idle", 32'(BUSY), 32'd0);
    cyc();
    chk("ldst_still_idle", 32'(BUSY), 32'd0);
    chk("ldst_no_tick", 32'(TICK), 32'd0);
    chk("ldst_dir_kept", 32'(DIG_UP), 32'd1);

    for (int t = 0; t < 8; t++) begin
      up = 1'b0;
      if ($urandom_range(0, 1) == 1) up = 1'b1;
      if (t % 2 == 0) begin
        raw = 16'($urandom_range(0, 65535));
        sval = bcd2int(clamp(raw));
      end else begin
        sval = $urandom_range(0, 12);
        if (up) sval = MAXV - sval;
        raw = int2bcd(sval);
      end
      do_load(raw);
      start_run(up);
      run_check(up, sval, 45);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Sequencing controller for a bank of NDIG cascaded single-digit BCD counters, forming a multi-digit up/down timer. Loads a preset into the bank, gates counting with an internal prescaled tick, and generates per-digit lookahead enables so every digit that changes does so on the same clock edge. Stops and flags DONE when the count reaches the terminal value (all 0 counting down, all 9 counting up). Sits between the user/front-panel logic and the digit datapath; the digits keep Q/CO, and this block owns ENABLE/LOAD/UP/D.

## Interface
Parameters:
- NDIG, 4, number of BCD digits (1..8)
- TICK_DIV, 3, CLK cycles per count tick (>=1)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- LOAD_REQ  in  1  load PRESET into the digits (aborts any run)
- START  in  1  start counting from IDLE, or resume from PAUSE
- STOP  in  1  pause counting in RUN
- UP_MODE  in  1  1 = count up, 0 = count down; sampled on START from IDLE
- PRESET  in  4*NDIG  preset digits, digit 0 in [3:0]
- DIG_Q  in  4*NDIG  current digit values from the bank
- DIG_ENABLE  out  NDIG  per-digit enable
- DIG_LOAD  out  1  load strobe to all digits
- DIG_UP  out  1  direction to all digits
- DIG_D  out  4*NDIG  load data to digits
- TICK  out  1  prescaler tick, one-cycle pulse
- BUSY  out  1  high in RUN or PAUSE
- DONE  out  1  terminal count reached

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Command priority: RST > LOAD_REQ > STOP > START. Commands are level-sampled each cycle.
- LOAD_REQ from any state -> LOAD for exactly one cycle; DIG_LOAD=1, DIG_ENABLE=all 1s, DIG_D=PRESET captured on the request edge; nibbles >9 are clamped to 9. Prescaler cleared. LOAD -> IDLE.
- IDLE + START -> RUN; latch UP_MODE into DIG_UP; clear prescaler.
- RUN: prescaler counts 0..TICK_DIV-1; TICK=1 in the cycle it equals TICK_DIV-1, then wraps to 0.
- Enables in RUN when TICK=1: DIG_ENABLE[0]=1; DIG_ENABLE[i]=1 iff every DIG_Q[j], j<i, is at its rollover value (9 up, 0 down). Otherwise DIG_ENABLE=0. DIG_LOAD=0 outside LOAD.
- Terminal check in RUN: if DIG_Q equals all 9s (up) or all 0s (down), go to DONE at the next edge, and force DIG_ENABLE=0 in that cycle even if TICK=1. This means the bank never wraps.
- RUN + STOP -> PAUSE; prescaler holds its value; no enables. PAUSE + START -> RUN, resuming the prescaler from the held value. DIG_UP is unchanged on resume.
- DONE: DONE=1; START and STOP are ignored. Leave only via LOAD_REQ or RST.
- START with the count already at terminal: RUN for one cycle with no enables, then DONE.

## Timing
- Reset values: state IDLE, DIG_ENABLE=0, DIG_LOAD=0, DIG_UP=1, DIG_D=0, TICK=0, BUSY=0, DONE=0, prescaler=0.
- State, prescaler, DIG_UP, DIG_D, TICK and DONE are registered.
- DIG_ENABLE is combinational from registered state, registered TICK and DIG_Q.
- The digit bank updates on the edge that ends an enabled cycle. The controller sees the new DIG_Q in the following cycle.
- Latencies: LOAD_REQ -> DIG_LOAD asserted in the next cycle. START -> first TICK TICK_DIV cycles after entering RUN. Terminal DIG_Q -> DONE=1 one cycle later.
- RST in mid-run returns to IDLE at the next edge. Digit contents are not touched.
- LOAD_REQ and START in the same cycle: the load wins; START is dropped.

## Structure
- Package bcd_ctrl_pkg holds the state enum and the constants BCD_MAX=4'd9 and BCD_MIN=4'd0.
- Sub-module tick_prescaler (parameter TICK_DIV) owns the prescaler. Ports: clr, run, hold -> tick.
- The clamp, lookahead-enable and terminal compare are generate loops in the top module.

## Test plan
Bench: NDIG=4, TICK_DIV=3, with a behavioral digit-bank model driven by DIG_* outputs.
- LOAD_REQ with PRESET=0x1A05 -> one-cycle DIG_LOAD with DIG_D=0x1905; bank reads 1905; back to IDLE.
- Load 0x0009, START with UP_MODE=1 -> one TICK every 3 cycles; first tick enables digits 0 and 1; bank reads 0010.
- Load 0x0003, START with UP_MODE=0 -> after 3 ticks the bank reads 0000 and DONE=1 one cycle later; no further enables; START ignored.
- Load 0x0999 counting up -> a tick enables digits 0..3 together; bank reads 1000 after a single edge.
- In RUN, assert STOP at prescaler=1 -> no TICK during PAUSE; START -> next TICK exactly 2 cycles later.
- RST during RUN -> IDLE next edge with all reset values; LOAD_REQ+START together -> load only, ends in IDLE.
